// File: rtl/reg_array.sv
// Integer register file storage: 32 x 64-bit enable-flops with a gated
// hierarchical write decoder; every register is exposed in parallel.
module reg_array #(
  parameter int NUM_REGS = 32,
  parameter int WIDTH    = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 31
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            RegWrite,
  input  logic [ADDR_W-1:0]               WriteRegister,
  input  logic [WIDTH-1:0]                WriteData,
  output logic [NUM_REGS-1:0][WIDTH-1:0]  regs_out,
  output logic [NUM_REGS-1:0]             write_onehot
);

  localparam int LO_W = 3;
  localparam int HI_W = ADDR_W - LO_W;
  localparam int NGRP = 2 ** HI_W;
  localparam int GSZ  = 2 ** LO_W;

  logic [NGRP-1:0]     grp_en;
  logic [NUM_REGS-1:0] dec_raw;
  logic [NUM_REGS-1:0] dec;

  // First stage: high address bits pick one 3:8 group, gated by RegWrite.
  always_comb begin
    grp_en = '0;
    if (RegWrite) grp_en[WriteRegister[ADDR_W-1:LO_W]] = 1'b1;
  end

  for (genvar g = 0; g < NGRP; g++) begin : g_dec
    logic [GSZ-1:0] sub;
    always_comb begin
      sub = '0;
      if (grp_en[g]) sub[WriteRegister[LO_W-1:0]] = 1'b1;
    end
    assign dec_raw[g*GSZ +: GSZ] = sub;
  end

  always_comb begin
    dec           = dec_raw;
    dec[ZERO_REG] = 1'b0;
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign regs_out[i] = '0;
    end else begin : g_ff
      logic [WIDTH-1:0] q;
      always_ff @(posedge clk) begin
        if (reset)       q <= '0;
        else if (dec[i]) q <= WriteData;
      end
      assign regs_out[i] = q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) write_onehot <= '0;
    else       write_onehot <= dec;
  end

endmodule

// File: tb/tb_reg_array.sv
// Self-checking bench for reg_array: table vectors plus
// sweep, zero-register and reset sequences, scoreboard-queued.
module tb_reg_array;

  localparam int N = 32;
  localparam int W = 64;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 RegWrite;
  logic [4:0]           WriteRegister;
  logic [W-1:0]         WriteData;
  logic [N-1:0][W-1:0]  regs_out;
  logic [N-1:0]         write_onehot;

  reg_array dut (
    .clk          (clk),
    .reset        (reset),
    .RegWrite     (RegWrite),
    .WriteRegister(WriteRegister),
    .WriteData    (WriteData),
    .regs_out     (regs_out),
    .write_onehot (write_onehot)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0][W-1:0] regs;
    logic [N-1:0]        oh;
  } exp_t;

  typedef struct {
    bit         rst;
    bit         we;
    logic [4:0] addr;
    logic [W-1:0] data;
    logic [W-1:0] exp_val;
    logic [N-1:0] exp_oh;
  } vec_t;

  int checks   = 0;
  int failures = 0;
  exp_t sb[$];
  logic [N-1:0][W-1:0] model = '0;
  bit mvalid = 0;

  task automatic cmp(input string nm, input logic [W-1:0] got,
                     input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  task automatic cmp_regs(input string nm, input logic [N-1:0][W-1:0] exp);
    int bad;
    bad = -1;
    checks++;
    for (int i = 0; i < N; i++)
      if (bad < 0 && regs_out[i] !== exp[i]) bad = i;
    if (bad >= 0) begin
      failures++;
      $display("FAIL %s reg=%0d got=%h exp=%h",
               nm, bad, regs_out[bad], exp[bad]);
    end
  endtask

  task automatic step(input bit r, input bit w, input logic [4:0] a,
                      input logic [W-1:0] d);
    exp_t e;
    exp_t p;
    @(negedge clk);
    reset = r; RegWrite = w; WriteRegister = a; WriteData = d;
    #1;
    if (mvalid) cmp_regs("no_write_through", model);
    if (r) model = '0;
    else if (w && a != 5'd31) model[a] = d;
    e.regs = model;
    e.oh   = (!r && w && a != 5'd31) ? (32'd1 << a) : 32'd0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    p = sb.pop_front();
    cmp_regs("regs", p.regs);
    cmp("onehot", W'(write_onehot), W'(p.oh));
    mvalid = 1;
  endtask

  vec_t vt[11];
  logic [W-1:0] pat;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    vt[0]  = '{1, 0, 5'd0,  64'h0, 64'h0, 32'h0};
    vt[1]  = '{0, 1, 5'd5,  64'hDEADBEEF_CAFEF00D,
               64'hDEADBEEF_CAFEF00D, 32'h0000_0020};
    vt[2]  = '{0, 0, 5'd5,  64'hFFFF, 64'hDEADBEEF_CAFEF00D, 32'h0};
    vt[3]  = '{0, 1, 5'd31, '1, 64'h0, 32'h0};
    vt[4]  = '{0, 0, 5'd7,  64'h1234, 64'h0, 32'h0};
    vt[5]  = '{1, 1, 5'd3,  64'h77, 64'h0, 32'h0};
    vt[6]  = '{0, 1, 5'd3,  64'hAAAA, 64'hAAAA, 32'h0000_0008};
    vt[7]  = '{0, 1, 5'd3,  64'h5555, 64'h5555, 32'h0000_0008};
    vt[8]  = '{0, 1, 5'd0,  64'h1, 64'h1, 32'h0000_0001};
    vt[9]  = '{0, 1, 5'd30, 64'h8000_0000_0000_0001,
               64'h8000_0000_0000_0001, 32'h4000_0000};
    vt[10] = '{0, 0, 5'd30, 64'h0, 64'h8000_0000_0000_0001, 32'h0};

    reset = 1'b0; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    #1;
    cmp("zero_before_reset", regs_out[31], 64'h0);

    for (int k = 0; k < 11; k++) begin
      step(vt[k].rst, vt[k].we, vt[k].addr, vt[k].data);
      cmp($sformatf("vec%0d_val", k), regs_out[vt[k].addr], vt[k].exp_val);
      cmp($sformatf("vec%0d_oh", k), W'(write_onehot), W'(vt[k].exp_oh));
    end

    // Disabled write with undriven address/data must change nothing.
    step(0, 0, 5'bx, 'x);

    for (int i = 0; i < 31; i++) begin
      pat = 64'(i) * 64'h0101_0101_0101_0101;
      step(0, 1, 5'(i), pat);
    end
    for (int i = 0; i < 31; i++) begin
      pat = 64'(i) * 64'h0101_0101_0101_0101;
      cmp($sformatf("sweep_r%0d", i), regs_out[i], pat);
    end

    step(0, 1, 5'd31, '1);
    cmp("xzr_write", regs_out[31], 64'h0);
    cmp("xzr_onehot", W'(write_onehot), 64'h0);

    step(1, 1, 5'd12, 64'hFEED);
    for (int i = 0; i < N; i++)
      cmp($sformatf("rst_r%0d", i), regs_out[i], 64'h0);
    step(0, 1, 5'd9, 64'h0123_4567_89AB_CDEF);
    cmp("post_rst_write", regs_out[9], 64'h0123_4567_89AB_CDEF);
    cmp("post_rst_oh", W'(write_onehot), 64'h200);
    step(0, 0, 5'd9, 64'h0);
    cmp("oh_clears", W'(write_onehot), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_array.md
Name: reg_array

Overview:
- Storage half of the 64-bit CPU register file: 32 x 64-bit registers with a gated 5:32 write decoder.
- Presents every register's contents in parallel to the downstream read-port mux trees (8:1 / 4:1 / 2:1 mux hierarchy, one tree per bit per read port).
- Sits between the writeback stage (source of write address, data and enable) and the read-port muxes; holds all architectural integer state.

Parameters:
- NUM_REGS, 32, number of registers; must equal 2**ADDR_W.
- WIDTH, 64, bits per register.
- ADDR_W, 5, write address width.
- ZERO_REG, 31, index of the hardwired-zero register (X31/XZR).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high; clears every register.
- RegWrite  input  1  write enable from writeback.
- WriteRegister  input  ADDR_W  destination register index.
- WriteData  input  WIDTH  data to store.
- regs_out  output  NUM_REGS x WIDTH  packed array; regs_out[i] is register i's current value, consumed by the read muxes.
- write_onehot  output  NUM_REGS  registered one-hot copy of the last accepted write's decode, for debug and verification; zero when no write occurred last cycle.

Behaviour:
- One clock domain (clk). Reset is synchronous and active-high, sampled on the rising edge of clk.
- Reset:
  - While reset=1 at a rising edge, all regs_out[i] become 0 and write_onehot becomes 0.
  - Reset has priority over any simultaneous write.
  - Reset asserted mid-sequence discards the pending write in that cycle; no partial update.
- Decode:
  - Combinational dec[i] = RegWrite and (WriteRegister == i), built as a 5:32 decoder gated by RegWrite.
  - At most one dec bit is high.
  - dec[ZERO_REG] is forced to 0.
- Storage:
  - Each register is WIDTH enable-flops: on a rising edge with reset=0, regs_out[i] <= dec[i] ? WriteData : regs_out[i].
  - Registers not addressed hold their value.
- Zero register:
  - regs_out[ZERO_REG] is constant 0 at all times, including before and after reset.
  - Writes to it are silently dropped and write_onehot stays 0 for that cycle.
- Latency:
  - A write is visible on regs_out one cycle after the edge that samples it; the new value appears immediately after that edge.
  - No same-cycle write-through: read muxes see the old value during the write cycle. Forwarding is the read side's concern.
- write_onehot:
  - On each non-reset edge, write_onehot <= dec.
  - It is therefore exactly one bit high for one cycle after a valid write, otherwise all zero.
- Back-to-back writes to the same register on consecutive cycles: the last one wins; each is visible for one cycle in order.
- RegWrite=0: no register changes regardless of WriteRegister/WriteData, including X/garbage on those inputs.
- Width rules:
  - WriteData is stored verbatim; no sign extension or truncation.
  - WriteRegister values are all legal (0..31).
- Structure:
  - The decoder is hierarchical (2:4 stage enabling 3:8 stages).
  - Storage is generate-instantiated enable-DFFs, matching the gate-level style of the existing mux trees.

Test Plan:
- Reset then idle: reset=1 one cycle, RegWrite=0 -> all regs_out = 0, write_onehot = 0.
- Single write:
  - Stimulus: RegWrite=1, WriteRegister=5, WriteData=64'hDEADBEEF_CAFEF00D, one edge.
  - Response: regs_out[5] = that value; all other registers 0; write_onehot = 32'h0000_0020 for one cycle, then 0.
- Sweep:
  - Stimulus: write value i*64'h0101_0101_0101_0101 to registers 0..30 on consecutive cycles.
  - Response: each value lands one cycle after its edge; previously written registers unchanged; final regs_out[i] match.
- Zero register and disable:
  - Stimulus 1: WriteRegister=31, WriteData=all 1s, RegWrite=1 -> regs_out[31] = 0, write_onehot = 0.
  - Stimulus 2: RegWrite=0, WriteRegister=7, WriteData=64'h1234 -> regs_out[7] unchanged.
- Priority and overwrite:
  - Stimulus 1: reset=1 and RegWrite=1 to register 3 in the same cycle -> regs_out[3] = 0.
  - Stimulus 2: write 64'hAAAA to register 3, then 64'h5555 to register 3 on the next cycle -> 64'hAAAA for one cycle, then 64'h5555.
- Reset mid-operation: populate registers 0..30, then assert reset one cycle -> every register 0 on the next cycle; a write the following cycle succeeds normally.
